// File: rtl/tri_buffer_pkg.sv
// Shared types and constants for the tri_buffer bus driver and its turnaround guard.
package tri_buffer_pkg;

    localparam int unsigned DRIVE_CNT_W = 16;
    localparam int unsigned TURN_CNT_W  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StTurn
    } guard_state_e;

endpackage

// File: rtl/tri_buffer_guard.sv
// Turnaround guard: after the bus is released, blocks re-driving for TURN_CYCLES cycles.
module tri_buffer_guard
    import tri_buffer_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic drive
);

    localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'(TURN_CYCLES - 1);

    guard_state_e                  state_q, state_d;
    logic         [TURN_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StDrive;
            end
            StDrive: begin
                if (!enable) begin
                    state_d = StTurn;
                    cnt_d   = TURN_LOAD;
                end
            end
            StTurn: begin
                // enable is ignored here; the bus stays released until the count runs out
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    assign drive = enable && (state_q != StTurn);

endmodule

// File: rtl/tri_buffer.sv
// Inverting tri-state bus driver with a saturating drive-cycle counter.
// Define TRI_BUFFER_TURNAROUND_EN to compile in the re-drive turnaround guard.
module tri_buffer
    import tri_buffer_pkg::*;
#(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned TURN_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       d,
    input  logic                   enable,
    output tri   [WIDTH-1:0]       y,
    output logic                   drive,
    output logic [DRIVE_CNT_W-1:0] drive_cnt
);

    if (TURN_CYCLES < 1 || TURN_CYCLES > 255) begin : g_bad_turn
        $error("tri_buffer: TURN_CYCLES must be in 1..255");
    end

`ifdef TRI_BUFFER_TURNAROUND_EN
    tri_buffer_guard #(
        .TURN_CYCLES(TURN_CYCLES)
    ) u_guard (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(enable),
        .drive (drive)
    );
`else
    assign drive = enable;
`endif

    // Purely combinational data path; no clock between d/enable and the bus.
    assign y = drive ? ~d : {WIDTH{1'bz}};

    logic [DRIVE_CNT_W-1:0] drive_cnt_q, drive_cnt_d;

    always_comb begin
        drive_cnt_d = drive_cnt_q;
        if (drive && (drive_cnt_q != {DRIVE_CNT_W{1'b1}})) begin
            drive_cnt_d = drive_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drive_cnt_q <= '0;
        else        drive_cnt_q <= drive_cnt_d;
    end

    assign drive_cnt = drive_cnt_q;

endmodule

// File: tb/tb_tri_buffer.sv
// Scoreboard bench for tri_buffer; guard sequences run when TRI_BUFFER_TURNAROUND_EN is defined.
module tb_tri_buffer;
    import tri_buffer_pkg::*;

    localparam int unsigned WIDTH       = 1;
    localparam int unsigned TURN_CYCLES = 2;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic [WIDTH-1:0] d      = '0;
    logic             enable = 1'b0;
    tri   [WIDTH-1:0] y;
    logic             drive;
    logic [15:0]      drive_cnt;

    // A released bus reads back as 0 through the pull.
    pulldown (y);

    always #5 clk = ~clk;

    tri_buffer #(
        .WIDTH      (WIDTH),
        .TURN_CYCLES(TURN_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .enable   (enable),
        .y        (y),
        .drive    (drive),
        .drive_cnt(drive_cnt)
    );

    typedef struct packed {
        logic        drv;
        logic        yv;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned m_cnt   = 0;
    logic        m_drv   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, ".drive"}, {31'd0, drive}, {31'd0, e.drv});
            check({tag, ".y"}, {31'd0, y}, {31'd0, e.yv});
            check({tag, ".cnt"}, {16'd0, drive_cnt}, {16'd0, e.cnt});
        end
    endtask

    // Drive inputs, push what the bus should show, then compare after settling.
    task automatic apply(input logic dv, input logic en, input logic exp_drv, input string tag);
        exp_t e;
        d      = dv;
        enable = en;
        m_drv  = exp_drv;
        e.drv  = exp_drv;
        e.yv   = exp_drv ? ~dv : 1'b0;
        e.cnt  = m_cnt[15:0];
        sb.push_back(e);
        #1;
        compare(tag);
    endtask

    task automatic tick();
        if (m_drv && rst_n && m_cnt != 32'hFFFF) m_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        apply(1'b0, 1'b0, 1'b0, "reset");
        rst_n = 1'b1;

        apply(1'b1, 1'b1, 1'b1, "en_d1");
        apply(1'b0, 1'b1, 1'b1, "en_d0");
        apply(1'b1, 1'b0, 1'b0, "dis_d1");
        apply(1'b0, 1'b0, 1'b0, "dis_d0");
        tick();
        apply(1'b0, 1'b0, 1'b0, "idle_no_cnt");

        apply(1'b1, 1'b1, 1'b1, "cnt_start");
        for (int i = 0; i < 5; i++) begin
            tick();
            apply(1'b1, 1'b1, 1'b1, "cnt_run");
        end
        check("cnt_is_5", {16'd0, drive_cnt}, 32'd5);

        // Asynchronous reset away from any edge clears the count at once.
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async.cnt", {16'd0, drive_cnt}, 32'd0);
        check("rst_async.drive", {31'd0, drive}, 32'd1);
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 1'b1, 1'b1, "post_rst");

`ifdef TRI_BUFFER_TURNAROUND_EN
        tick();
        apply(1'b1, 1'b1, 1'b1, "g_drive");
        apply(1'b0, 1'b0, 1'b0, "g_fall");
        tick();
        apply(1'b0, 1'b1, 1'b0, "g_turn_first");
        for (int i = 0; i < int'(TURN_CYCLES) - 1; i++) begin
            tick();
            apply(1'b0, 1'b1, 1'b0, "g_turn_hold");
        end
        tick();
        apply(1'b0, 1'b1, 1'b1, "g_redrive");
        tick();
        apply(1'b1, 1'b1, 1'b1, "g_drive2");

        // Reset in the middle of the turnaround releases the guard immediately.
        apply(1'b1, 1'b0, 1'b0, "g_fall2");
        tick();
        apply(1'b1, 1'b1, 1'b0, "g_turn2");
        #2;
        rst_n = 1'b0;
        #1;
        check("g_rst_abort.drive", {31'd0, drive}, 32'd1);
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 1'b1, 1'b1, "g_after_rst");
`endif

        // Preload the counter just below saturation.
        force dut.drive_cnt_q = 16'hFFFC;
        #1;
        release dut.drive_cnt_q;
        m_cnt = 32'hFFFC;
        apply(1'b0, 1'b1, 1'b1, "sat_pre");
        for (int i = 0; i < 6; i++) begin
            tick();
            apply(1'b0, 1'b1, 1'b1, "sat_run");
        end
        check("sat_hold", {16'd0, drive_cnt}, 32'h0000FFFF);

        apply(1'b0, 1'b0, 1'b0, "final_release");
        tick();
        apply(1'b0, 1'b0, 1'b0, "final_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
